// File: rtl/imm_gen_if.sv
// Handshake bus for the immediate generator: instruction in, decoded
// immediate out. The producer/consumer side uses master; the block uses slave.
interface imm_gen_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator. The instruction is decoded combinationally at
// the input and the result is written into a 2-entry output FIFO, so a
// decoded immediate appears one cycle after acceptance when the FIFO is empty.
module imm_gen_pipe #(
    parameter int XLEN     = 64,
    parameter int EN_UTYPE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_gen_if.slave         bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [31:0]     ins;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec;
    entry_t          mem [2];
    entry_t          head;
    logic            wptr, rptr;
    logic [1:0]      count;
    logic            push, pop;

    assign ins = bus.in_instr;

    // Opcode classification and 32-bit immediate assembly (U already 32 bits wide).
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_fmt = FMT_I;
                imm32   = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64.
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                if (EN_UTYPE != 0) begin
                    dec_fmt = FMT_U;
                    imm32   = {ins[31:12], 12'b0};
                end
            end
            default: ;
        endcase
    end

    // Widen to XLEN; on RV32 the 32-bit value is already final.
    generate
        if (XLEN == 64) begin : g_ext64
            assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_ext32
            assign dec_imm = imm32;
        end
    endgenerate

    assign dec.imm     = dec_imm;
    assign dec.fmt     = dec_fmt;
    assign dec.illegal = (dec_fmt == FMT_NONE);

    // Handshakes; in_ready depends only on registered occupancy.
    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign head            = mem[rptr];
    assign bus.out_imm     = bus.out_valid ? head.imm : '0;
    assign bus.out_fmt     = bus.out_valid ? head.fmt : FMT_NONE;
    assign bus.out_illegal = bus.out_valid & head.illegal;

    // FIFO storage; stale entries are invisible because outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end

    // Pointers, occupancy and saturating illegal counter; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            count       <= 2'd0;
            illegal_cnt <= '0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (pop && head.illegal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end
endmodule
